// File: rtl/sprite_anim_rom.sv
`default_nettype none
// ============================================================================
// Module      : sprite_anim_rom
// Description : Multi-frame sprite memory with a built-in animation sequencer.
//               Holds FRAMES images of SPR_W x SPR_H 24-bit RGB pixels.
//               Advances the displayed frame every FRAME_CYCLES clocks in
//               loop, ping-pong, one-shot or hold mode. Serves pixels by
//               (x,y) with a fixed 2-cycle read latency.
// Ports       : Clk, Reset        - clock, asynchronous active-high reset
//               anim_en, mode     - run enable, 0 loop/1 ping-pong/2 one-shot/3 hold
//               restart           - pulse: frame 0, counter 0, forward, done cleared
//               we, wr_frame,
//               wr_addr, data_In  - synchronous pixel write port
//               rd_x, rd_y,
//               rd_req            - read request (coordinates + qualifier)
//               data_Out,
//               rd_valid          - registered pixel color and its qualifier
//               frame_idx         - currently displayed frame
//               anim_done         - one-shot sequence finished (sticky)
// Options     : MIRROR_X_EN - adds input flip_x; reads use column SPR_W-1-rd_x
//               when flip_x=1 (range check stays on the unflipped rd_x).
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_anim_rom #(
  parameter int          SPR_W        = 45,
  parameter int          SPR_H        = 45,
  parameter int          FRAMES       = 2,
  parameter int          FRAME_CYCLES = 12500000,
  parameter logic [23:0] TRANSPARENT  = 24'hFFFFFF,
  // Names the preload images (INIT_PREFIX_<f+1>.txt) for the integration flow.
  parameter              INIT_PREFIX  = "sprite",
  localparam int         FW           = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int         AW           = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          anim_en,
  input  logic [1:0]    mode,
  input  logic          restart,
  input  logic          we,
  input  logic [FW-1:0] wr_frame,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   data_In,
  input  logic [9:0]    rd_x,
  input  logic [9:0]    rd_y,
  input  logic          rd_req,
`ifdef MIRROR_X_EN
  input  logic          flip_x,
`endif
  output logic [23:0]   data_Out,
  output logic          rd_valid,
  output logic [FW-1:0] frame_idx,
  output logic          anim_done
);

  localparam int PIX   = SPR_W * SPR_H;
  localparam int DEPTH = FRAMES * PIX;
  localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  localparam logic [1:0]    MODE_LOOP    = 2'd0;
  localparam logic [1:0]    MODE_PING    = 2'd1;
  localparam logic [1:0]    MODE_ONESHOT = 2'd2;
  localparam logic [1:0]    MODE_HOLD    = 2'd3;
  localparam logic [FW-1:0] FRAME_LAST   = FW'(FRAMES - 1);
  localparam logic [CW-1:0] CNT_LAST     = CW'(FRAME_CYCLES - 1);

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_BWD = 1'b1
  } dir_t;

  // --------------------------------------------------------------------------
  // Animation sequencer
  // --------------------------------------------------------------------------
  logic [CW-1:0] r_cnt;
  dir_t          r_dir;
  logic          w_run;
  logic          w_adv;

  // A finished one-shot stops the counter; other modes keep running even
  // though anim_done stays set until restart/Reset.
  assign w_run = anim_en && (mode != MODE_HOLD) && !((mode == MODE_ONESHOT) && anim_done);
  assign w_adv = w_run && (r_cnt == CNT_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt     <= '0;
      r_dir     <= DIR_FWD;
      frame_idx <= '0;
      anim_done <= 1'b0;
    end else if (restart) begin
      r_cnt     <= '0;
      r_dir     <= DIR_FWD;
      frame_idx <= '0;
      anim_done <= 1'b0;
    end else if (w_run) begin
      r_cnt <= w_adv ? '0 : r_cnt + CW'(1);
      if (w_adv) begin
        case (mode)
          MODE_LOOP: begin
            frame_idx <= (frame_idx == FRAME_LAST) ? '0 : frame_idx + FW'(1);
          end
          MODE_PING: begin
            // Ends are bounced off, not repeated; a single frame never moves.
            if (FRAMES > 1) begin
              if (r_dir == DIR_FWD) begin
                if (frame_idx == FRAME_LAST) begin
                  frame_idx <= frame_idx - FW'(1);
                  r_dir     <= DIR_BWD;
                end else begin
                  frame_idx <= frame_idx + FW'(1);
                end
              end else begin
                if (frame_idx == '0) begin
                  frame_idx <= frame_idx + FW'(1);
                  r_dir     <= DIR_FWD;
                end else begin
                  frame_idx <= frame_idx - FW'(1);
                end
              end
            end
          end
          MODE_ONESHOT: begin
            if (frame_idx == FRAME_LAST) begin
              anim_done <= 1'b1;
            end else begin
              frame_idx <= frame_idx + FW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline, stage 1: range check, linear address, frame snapshot
  // --------------------------------------------------------------------------
  logic [9:0]    w_col;
  logic          w_in_range;
  logic [AW-1:0] w_rd_addr;

`ifdef MIRROR_X_EN
  assign w_col = flip_x ? (10'(SPR_W - 1) - rd_x) : rd_x;
`else
  assign w_col = rd_x;
`endif

  assign w_in_range = (32'(rd_x) < SPR_W) && (32'(rd_y) < SPR_H);
  assign w_rd_addr  = w_in_range ? (AW'(rd_y) * AW'(SPR_W) + AW'(w_col)) : '0;

  logic          r_s1_req;
  logic          r_s1_inr;
  logic [AW-1:0] r_s1_addr;
  logic [FW-1:0] r_s1_frame;

  // The frame is captured alongside the address so a frame change between
  // the two stages cannot mix pixels from different images.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1_req   <= 1'b0;
      r_s1_inr   <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_frame <= '0;
    end else begin
      r_s1_req   <= rd_req;
      r_s1_inr   <= w_in_range;
      r_s1_addr  <= w_rd_addr;
      r_s1_frame <= frame_idx;
    end
  end

  // --------------------------------------------------------------------------
  // Pixel memory (not reset) and stage 2 output register
  // --------------------------------------------------------------------------
  logic [23:0]   r_mem [DEPTH];
  logic          w_wr_ok;
  logic [MW-1:0] w_wr_idx;
  logic [MW-1:0] w_rd_idx;

  assign w_wr_ok  = we && (32'(wr_addr) < PIX) && (32'(wr_frame) < FRAMES);
  assign w_wr_idx = MW'(wr_frame) * MW'(PIX) + MW'(wr_addr);
  assign w_rd_idx = MW'(r_s1_frame) * MW'(PIX) + MW'(r_s1_addr);

  always_ff @(posedge Clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_idx] <= data_In;
    end
  end

  // Reading here while the write lands on the same edge yields the old word.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      data_Out <= TRANSPARENT;
      rd_valid <= 1'b0;
    end else begin
      data_Out <= r_s1_inr ? r_mem[w_rd_idx] : TRANSPARENT;
      rd_valid <= r_s1_req;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim_rom.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_anim_rom
// Description : Self-checking bench. Instance A (45x45, 2 frames, 4 cycles
//               per frame) covers loop mode, hold, memory and the read
//               pipeline; instance B (4x4, 3 frames, 1 cycle per frame)
//               covers ping-pong, one-shot, restart and 3-frame loop.
//               Read results are checked by a queue-based scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_anim_rom;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A signals
  logic        a_anim_en, a_restart, a_we, a_rd_req, a_flip;
  logic [1:0]  a_mode;
  logic [0:0]  a_wr_frame;
  logic [10:0] a_wr_addr;
  logic [23:0] a_data_in;
  logic [9:0]  a_rd_x, a_rd_y;
  logic [23:0] a_data_out;
  logic        a_rd_valid, a_done;
  logic [0:0]  a_frame;

  // Instance B signals
  logic        b_anim_en, b_restart, b_we, b_rd_req, b_flip;
  logic [1:0]  b_mode;
  logic [1:0]  b_wr_frame;
  logic [3:0]  b_wr_addr;
  logic [23:0] b_data_in;
  logic [9:0]  b_rd_x, b_rd_y;
  logic [23:0] b_data_out;
  logic        b_rd_valid, b_done;
  logic [1:0]  b_frame;

  sprite_anim_rom #(
    .SPR_W(45), .SPR_H(45), .FRAMES(2), .FRAME_CYCLES(4)
  ) u_dut_a (
    .Clk(clk), .Reset(rst), .anim_en(a_anim_en), .mode(a_mode),
    .restart(a_restart), .we(a_we), .wr_frame(a_wr_frame),
    .wr_addr(a_wr_addr), .data_In(a_data_in), .rd_x(a_rd_x),
    .rd_y(a_rd_y), .rd_req(a_rd_req),
`ifdef MIRROR_X_EN
    .flip_x(a_flip),
`endif
    .data_Out(a_data_out), .rd_valid(a_rd_valid),
    .frame_idx(a_frame), .anim_done(a_done)
  );

  sprite_anim_rom #(
    .SPR_W(4), .SPR_H(4), .FRAMES(3), .FRAME_CYCLES(1)
  ) u_dut_b (
    .Clk(clk), .Reset(rst), .anim_en(b_anim_en), .mode(b_mode),
    .restart(b_restart), .we(b_we), .wr_frame(b_wr_frame),
    .wr_addr(b_wr_addr), .data_In(b_data_in), .rd_x(b_rd_x),
    .rd_y(b_rd_y), .rd_req(b_rd_req),
`ifdef MIRROR_X_EN
    .flip_x(b_flip),
`endif
    .data_Out(b_data_out), .rd_valid(b_rd_valid),
    .frame_idx(b_frame), .anim_done(b_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] d;
    int          due;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every valid output pops one expected read.
  always @(negedge clk) begin : mon
    exp_t e;
    if (a_rd_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: rd_valid=1 data_Out=%h with no read outstanding", a_data_out);
      end else begin
        e = q.pop_front();
        chk("rd_data", a_data_out, e.d);
        chk("rd_latency", cyc, e.due);
      end
    end
  end

  // Called just after a rising edge; issues one read this cycle.
  task automatic rd(input logic [9:0] x, input logic [9:0] y, input logic [23:0] d);
    a_rd_x   = x;
    a_rd_y   = y;
    a_rd_req = 1'b1;
    q.push_back('{d: d, due: cyc + 2});
    @(posedge clk); #1;
    a_rd_req = 1'b0;
  endtask

  task automatic wr(input logic [0:0] f, input logic [10:0] a, input logic [23:0] d);
    a_we       = 1'b1;
    a_wr_frame = f;
    a_wr_addr  = a;
    a_data_in  = d;
    @(posedge clk); #1;
    a_we = 1'b0;
  endtask

  int seq_a  [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  int seq_pp [6] = '{0, 1, 2, 1, 0, 1};
  int seq_os [4] = '{0, 1, 2, 2};
  int done_os[4] = '{0, 0, 0, 1};
  int seq_lp [3] = '{1, 2, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_anim_en = 1'b1; a_mode = 2'd0; a_restart = 1'b0; a_we = 1'b0;
    a_wr_frame = '0; a_wr_addr = '0; a_data_in = '0;
    a_rd_x = '0; a_rd_y = '0; a_rd_req = 1'b0; a_flip = 1'b0;
    b_anim_en = 1'b0; b_mode = 2'd1; b_restart = 1'b0; b_we = 1'b0;
    b_wr_frame = '0; b_wr_addr = '0; b_data_in = '0;
    b_rd_x = '0; b_rd_y = '0; b_rd_req = 1'b0; b_flip = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data", a_data_out, 24'hFFFFFF);
    chk("reset_valid", a_rd_valid, 0);
    chk("reset_frame", a_frame, 0);
    chk("reset_done", a_done, 0);
    @(posedge clk); #1 rst = 1'b0;

    // A: loop mode, 2 frames x 4 cycles
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("loop_frame[%0d]", i), a_frame, seq_a[i]);
    end
    chk("loop_done", a_done, 0);
    repeat (4) @(posedge clk);
    #1 a_mode = 2'd3;
    @(negedge clk);
    chk("hold_frame", a_frame, 1);

    // B: ping-pong, 3 frames, advance every cycle
    @(posedge clk); #1 b_anim_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("pp_frame[%0d]", i), b_frame, seq_pp[i]);
    end

    // B: one-shot from a restart
    @(posedge clk); #1 b_mode = 2'd2; b_restart = 1'b1;
    @(posedge clk); #1 b_restart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      chk($sformatf("os_frame[%0d]", i), b_frame, seq_os[i]);
      chk($sformatf("os_done[%0d]", i), b_done, done_os[i]);
    end
    @(posedge clk); #1 b_mode = 2'd3;
    @(negedge clk);
    chk("os_hold_frame", b_frame, 2);
    chk("os_done_sticky", b_done, 1);
    @(posedge clk); #1 b_restart = 1'b1;
    @(posedge clk); #1 b_restart = 1'b0; b_mode = 2'd0;
    @(negedge clk);
    chk("restart_frame_b", b_frame, 0);
    chk("restart_done_b", b_done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("loop3_frame[%0d]", i), b_frame, seq_lp[i]);
    end

    // A: memory and read pipeline (held at frame 1)
    @(posedge clk); #1;
    wr(1'b1, 11'd46,   24'h123456);
    wr(1'b0, 11'd46,   24'hABCDEF);
    wr(1'b1, 11'd0,    24'h0000AA);
    wr(1'b1, 11'd2024, 24'h00BEEF);
    wr(1'b0, 11'd2025, 24'hDEAD00);  // out of range: must not alias frame 1 addr 0
    rd(10'd1,    10'd1,    24'h123456);
    rd(10'd0,    10'd0,    24'h0000AA);
    rd(10'd44,   10'd44,   24'h00BEEF);
    rd(10'd45,   10'd0,    24'hFFFFFF);
    rd(10'd0,    10'd45,   24'hFFFFFF);
    rd(10'd1023, 10'd1023, 24'hFFFFFF);
    // Restart lands while this read is in stage 1: it must still see frame 1.
    a_restart = 1'b1;
    rd(10'd1, 10'd1, 24'h123456);
    a_restart = 1'b0;
    @(negedge clk);
    chk("restart_frame_a", a_frame, 0);
    chk("restart_done_a", a_done, 0);
    @(posedge clk); #1;
    rd(10'd1, 10'd1, 24'hABCDEF);    // old word: write commits on its stage-2 edge
    a_we = 1'b1; a_wr_frame = 1'b0; a_wr_addr = 11'd46; a_data_in = 24'h777777;
    rd(10'd1, 10'd1, 24'h777777);
    a_we = 1'b0;
    // Unrequested read still updates data_Out
    a_rd_x = 10'd45; a_rd_y = 10'd0; a_rd_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("noreq_data", a_data_out, 24'hFFFFFF);
    chk("noreq_valid", a_rd_valid, 0);

    // A: reset with reads in flight
    @(posedge clk); #1 a_mode = 2'd0;
    repeat (4) @(posedge clk);
    #1;
    rd(10'd44, 10'd44, 24'h00BEEF);
    a_rd_x = 10'd1; a_rd_y = 10'd1; a_rd_req = 1'b1;  // dropped by reset
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_frame", a_frame, 1);
    #1 rst = 1'b1; a_rd_req = 1'b0;
    #1;
    chk("mid_reset_valid", a_rd_valid, 0);
    chk("mid_reset_frame", a_frame, 0);
    chk("mid_reset_data", a_data_out, 24'hFFFFFF);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_valid", a_rd_valid, 0);
    chk("sb_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_anim_rom.md
Name: sprite_anim_rom

Overview:
Parametrised multi-frame sprite memory with a built-in animation sequencer. It replaces per-sprite, two-frame, timestamp-modulo RAMs with one generic block. Each instance holds FRAMES images of SPR_W x SPR_H 24-bit RGB pixels, advances frames on an internal cycle counter in one of four modes, and serves pixels by (x,y) coordinate to the color mapper with fixed 2-cycle latency.

Parameters:
SPR_W, 45, sprite width in pixels
SPR_H, 45, sprite height in pixels
FRAMES, 2, number of animation frames (>=1)
FRAME_CYCLES, 12500000, Clk cycles each frame is shown (>=1)
TRANSPARENT, 24'hFFFFFF, color returned for out-of-range reads
INIT_PREFIX, "sprite", hex file prefix; frame f loads INIT_PREFIX_<f+1>.txt

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
anim_en  in  1  1 = frame counter runs; 0 = counter and frame frozen
mode  in  2  0 loop, 1 ping-pong, 2 one-shot, 3 hold
restart  in  1  one-cycle pulse: frame 0, counter 0, direction forward, done cleared
we  in  1  write enable
wr_frame  in  clog2(FRAMES) max 1  frame written
wr_addr  in  clog2(SPR_W*SPR_H)  linear pixel address written
data_In  in  24  write data
rd_x  in  10  pixel x within sprite
rd_y  in  10  pixel y within sprite
rd_req  in  1  read request qualifier
data_Out  out  24  pixel color, registered
rd_valid  out  1  data_Out corresponds to rd_req 2 cycles earlier
frame_idx  out  clog2(FRAMES) max 1  currently displayed frame
anim_done  out  1  one-shot sequence finished (sticky)

Behaviour:
- Reset values: data_Out = TRANSPARENT, rd_valid = 0, frame_idx = 0, anim_done = 0, cycle counter = 0, direction = forward. Memory contents are not affected by Reset.
- Cycle counter: increments while anim_en=1 and mode != 3. At FRAME_CYCLES-1 it wraps to 0 and issues a one-cycle advance.
- Advance, loop: frame = (frame+1) mod FRAMES.
- Advance, ping-pong: moves forward until FRAMES-1, then reverses; moves backward until 0, then reverses. End frames are not repeated (FRAMES=3 gives 0,1,2,1,0,1...). FRAMES=2 alternates 0,1.
- Advance, one-shot: increments until FRAMES-1. On the advance that would pass FRAMES-1, frame holds and anim_done is set. Once done, the counter stops.
- Hold (mode 3): counter and frame frozen.
- FRAMES=1: frame_idx is constantly 0. In one-shot, anim_done sets on the first advance.
- restart has priority over advance in the same cycle. A mode change mid-sequence keeps the current frame and direction. Leaving one-shot does not clear anim_done; only restart or Reset clears it.
- Read pipeline:
  - Stage 1 registers in_range = (rd_x<SPR_W && rd_y<SPR_H), addr = rd_y*SPR_W+rd_x (computed only when in range), the frame_idx sampled that cycle, and rd_req.
  - Stage 2 registers data_Out = in_range ? mem[frame][addr] : TRANSPARENT, and rd_valid = stage-1 rd_req.
  - Latency is 2 cycles, fully pipelined, one read per cycle. A frame change never tears a single pixel, because the frame is latched with the address.
  - data_Out updates even when rd_req=0; only rd_valid qualifies it.
- Write: synchronous. Writes are ignored if wr_addr >= SPR_W*SPR_H or wr_frame >= FRAMES. A read of the same location in the same cycle returns the old data (read-before-write).
- Reset mid-read: pipeline valids clear immediately (asynchronous). In-flight reads are dropped.

Optional Feature:
MIRROR_X_EN
- Defined: adds input flip_x (1 bit). When flip_x=1 at request time, stage 1 uses column SPR_W-1-rd_x. The range check still applies to the unflipped rd_x. Latency is unchanged.
- Undefined: no flip_x port; column = rd_x.

Test Plan:
- Reset, FRAMES=2, FRAME_CYCLES=4, mode 0, anim_en=1 -> frame_idx sequence 0,0,0,0,1,1,1,1,0; anim_done stays 0.
- FRAMES=3, FRAME_CYCLES=1, mode 1 -> frame_idx 0,1,2,1,0,1 on successive cycles.
- FRAMES=3, mode 2 -> frame_idx holds at 2; anim_done=1 on the next wrap; restart pulse -> frame_idx=0, anim_done=0 next cycle.
- Write 24'h123456 to frame 1, addr 46; read rd_x=1, rd_y=1 while frame_idx=1 with rd_req=1 -> two cycles later data_Out=24'h123456, rd_valid=1.
- Read rd_x=45, rd_y=0 -> data_Out=24'hFFFFFF. A write with wr_addr=2025 leaves memory unchanged.
- Assert Reset mid-stream with reads in flight -> rd_valid=0, frame_idx=0, data_Out=TRANSPARENT immediately.
